data_mem_mp: RTL
================

// Module: data_mem_mp
// PURPOSE
//  Multi-port, parametrised frame-buffer data memory with round-robin arbitration.
//  Each requester port supports byte-enabled writes. Reads return after a fixed, pipelined latency.
//  A tagged read-return bus identifies the requesting port.
//  The memory can be cleared after reset by an internal sweep.
//  Sits between the frame-buffer producer/consumer engines and storage, replacing the single-port data memory.
// PARAMETERS
//  DATA_WIDTH     32             word width in bits; must be a multiple of 8
//  ADDR_WIDTH     10             address width
//  MEM_DEPTH      1<<ADDR_WIDTH  number of words; must be <= 1<<ADDR_WIDTH
//  NUM_PORTS      2              requester ports, 1..8
//  RD_LATENCY     2              cycles from read grant to rd_valid, 1..4
//  CLEAR_ON_RESET 1              1: zero all words after reset; 0: contents kept
// PORTS
//  clk        in   1                       clock, all logic on rising edge
//  reset      in   1                       synchronous, active-high
//  req        in   NUM_PORTS               per-port request, active-high
//  we         in   NUM_PORTS               per-port 1=write, 0=read
//  addr       in   NUM_PORTS*ADDR_WIDTH    per-port address; port p = [p*AW +: AW]
//  wdata      in   NUM_PORTS*DATA_WIDTH    per-port write data
//  be         in   NUM_PORTS*DATA_WIDTH/8  per-port byte enables
//  gnt        out  NUM_PORTS               one-hot grant pulse, one cycle
//  rd_valid   out  1                       read data valid pulse
//  rd_port    out  3                       index of the port owning rd_data
//  rd_data    out  DATA_WIDTH              read return data
//  addr_err   out  1                       pulse: granted access had addr >= MEM_DEPTH
//  busy       out  1                       high while the clear sweep runs
// BEHAVIOUR
//  Reset
//   - While reset=1 at an edge: gnt=0, rd_valid=0, rd_port=0, rd_data=0, addr_err=0.
//   - Also: read pipeline flushed; round-robin pointer set to port NUM_PORTS-1.
//   - State <= INIT if CLEAR_ON_RESET, else RUN.
//   - Reset mid-sweep or mid-read restarts the sweep and drops in-flight reads; no rd_valid for them.
//  FSM
//   - INIT: busy=1, gnt=0. Writes 0 to word clr_cnt (0..MEM_DEPTH-1), one word per cycle.
//     After word MEM_DEPTH-1 -> RUN; busy falls on the next cycle.
//     Sweep takes exactly MEM_DEPTH cycles.
//   - RUN: busy=0. Arbitration runs every cycle. No exit except reset.
//  Arbitration / handshake
//   - Requester holds req, we, addr, wdata, be stable until it sees gnt.
//   - gnt is combinational from the registered pointer and current req, so grant is same-cycle.
//   - At most one grant per cycle.
//   - Search starts at pointer+1 (mod NUM_PORTS); the first port with req=1 wins.
//   - Pointer <= winner on a grant; otherwise unchanged.
//   - A port may deassert req only after gnt. Dropping req earlier withdraws the request; no side effect.
//  Write
//   - On the grant edge, byte k of mem[addr] <= wdata byte k where be[k]=1; other bytes unchanged.
//   - be=0 is a legal no-op write that still consumes a grant.
//  Read
//   - mem[addr] is sampled at the grant edge and returned RD_LATENCY cycles after the grant cycle.
//   - Return carries rd_valid=1 and rd_port=winner.
//   - Fully pipelined: one read return per cycle sustained; returns in grant order.
//   - rd_data holds its last value when rd_valid=0.
//   - A read granted the cycle after a write to the same address returns the new data.
//  Out-of-range address
//   - Write is dropped; read returns 0 with rd_valid=1.
//   - addr_err pulses in the cycle after the grant.
// TESTING
//  T1 Reset, CLEAR_ON_RESET=1, MEM_DEPTH=16:
//     busy high 16 cycles, gnt stays 0 despite req=2'b11; after sweep, read addr 5 -> rd_data=0.
//  T2 Port0 write addr 3, wdata=32'hA5A5_1234, be=4'hF; then port1 read addr 3:
//     rd_valid 2 cycles after grant, rd_port=1, rd_data=32'hA5A5_1234.
//  T3 Byte enables: word 7=32'h1122_3344, write 32'hFFFF_FFFF with be=4'b0101
//     -> read returns 32'h11FF_33FF.
//  T4 req=2'b11 held for 4 cycles, pointer at port1 after reset:
//     gnt sequence 01,10,01,10; back-to-back reads give 4 consecutive rd_valid with rd_port 0,1,0,1.
//  T5 Port0 read addr=20 with MEM_DEPTH=16:
//     addr_err pulse the cycle after grant; rd_data=0, rd_valid=1; memory unchanged.
//  T6 Reset asserted 1 cycle after a read grant (RD_LATENCY=2):
//     no rd_valid appears; busy rises; sweep restarts at word 0.

Source files
------------

// File: rtl/data_mem_mp.sv
// Multi-port frame-buffer data memory: round-robin arbitration, byte-enabled writes,
// pipelined tagged read returns and an optional post-reset clear sweep.
module data_mem_mp #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int MEM_DEPTH      = 1 << ADDR_WIDTH,
  parameter int NUM_PORTS      = 2,
  parameter int RD_LATENCY     = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_PORTS-1:0]               req,
  input  logic [NUM_PORTS-1:0]               we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]    wdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]  be,
  output logic [NUM_PORTS-1:0]               gnt,
  output logic                               rd_valid,
  output logic [2:0]                         rd_port,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic                               addr_err,
  output logic                               busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
  logic [PW-1:0]           ptr_q, winner;
  logic                    gnt_any;
  int                      cand;

  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [BYTES-1:0]        sel_be;
  logic                    in_range, wr_go, rd_go;
  logic [IDX_W-1:0]        idx;
  logic [DATA_WIDTH-1:0]   rd_word;

  logic                    pv    [RD_LATENCY];
  logic [2:0]              pport [RD_LATENCY];
  logic [DATA_WIDTH-1:0]   pdata [RD_LATENCY];

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? INIT : RUN;
      clr_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      INIT: begin
        busy = 1'b1;
        if (clr_cnt == IDX_W'(MEM_DEPTH - 1)) state_d = RUN;
      end
      default: ;
    endcase
  end

  // Round-robin: search begins one past the last winner; grant is same-cycle.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    winner  = '0;
    cand    = 0;
    if (state_q == RUN && !reset) begin
      for (int i = 1; i <= NUM_PORTS; i++) begin
        cand = (int'(ptr_q) + i) % NUM_PORTS;
        if (!gnt_any && req[cand]) begin
          gnt_any = 1'b1;
          winner  = PW'(cand);
        end
      end
    end
    gnt[winner] = gnt_any;
  end

  assign sel_we    = we[winner];
  assign sel_addr  = addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = wdata[winner*DATA_WIDTH +: DATA_WIDTH];
  assign sel_be    = be[winner*BYTES +: BYTES];
  assign in_range  = {1'b0, sel_addr} < (ADDR_WIDTH + 1)'(MEM_DEPTH);
  assign idx       = sel_addr[IDX_W-1:0];
  assign wr_go     = gnt_any & sel_we & in_range;
  assign rd_go     = gnt_any & ~sel_we;
  assign rd_word   = in_range ? mem[idx] : '0;

  // NOTE: the storage array has no reset; clearing it is the job of the INIT sweep.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[clr_cnt] <= '0;
    end else if (wr_go) begin
      for (int k = 0; k < BYTES; k++)
        if (sel_be[k]) mem[idx][k*8 +: 8] <= sel_wdata[k*8 +: 8];
    end
  end

  // Read pipeline: data only advances behind a valid entry, so the last stage holds its value.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= PW'(NUM_PORTS - 1);
      addr_err <= 1'b0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pv[i]    <= 1'b0;
        pport[i] <= '0;
        pdata[i] <= '0;
      end
    end else begin
      if (gnt_any) ptr_q <= winner;
      addr_err <= gnt_any & ~in_range;
      pv[0]    <= rd_go;
      if (rd_go) begin
        pdata[0] <= rd_word;
        pport[0] <= 3'(winner);
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) begin
          pdata[i] <= pdata[i-1];
          pport[i] <= pport[i-1];
        end
      end
    end
  end

  assign rd_valid = pv[RD_LATENCY-1];
  assign rd_port  = pport[RD_LATENCY-1];
  assign rd_data  = pdata[RD_LATENCY-1];

endmodule
